// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done handshake.
// One operand bit per cycle; result is bin mod 10^DIGITS, ovf flags truncation.
module bcd_seq_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   corr;
  logic            sticky_q, sticky_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d, ovf_d;
  logic [AW-1:0]   bcd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      bcd      <= bcd_d;
      ovf      <= ovf_d;
    end
  end

  // Per-digit add-3 correction; digits are independent, no carry between them.
  always_comb begin
    corr = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    bcd_d    = bcd;
    ovf_d    = ovf;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d     = bin;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Bit shifted out of the top digit means the value needs more digits.
        acc_d    = {corr[AW-2:0], sr_q[WIDTH-1]};
        sr_d     = sr_q << 1;
        sticky_d = sticky_q | corr[AW-1];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = {corr[AW-2:0], sr_q[WIDTH-1]};
          ovf_d   = sticky_q | corr[AW-1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: a 3-digit and a 2-digit instance, directed
// vectors plus a 0..255 sweep; monitors pop expected results on each done pulse.
module tb_bcd_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic [7:0]  bin, bin2;
  logic        busy, done, ovf;
  logic [11:0] bcd;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bcd_seq_ctrl #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  typedef struct packed { logic [11:0] b; logic o; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Monitor for 3-digit instance; also checks busy was high exactly 8 cycles before done.
  initial begin
    int run;
    exp_t e;
    run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) run = 0;
      else begin
        if (done) begin
          if (q1.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_done3: got done=1 expected no done at %0t", $time);
          end else begin
            e = q1.pop_front();
            check("bcd3", {20'd0, bcd}, {20'd0, e.b});
            check("ovf3", {31'd0, ovf}, {31'd0, e.o});
            check("busy_len3", run, 8);
          end
        end
        if (busy) run++;
        else run = 0;
      end
    end
  end

  initial begin
    int run;
    exp_t e;
    run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) run = 0;
      else begin
        if (done2) begin
          if (q2.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_done2: got done=1 expected no done at %0t", $time);
          end else begin
            e = q2.pop_front();
            check("bcd2", {24'd0, bcd2}, {24'd0, e.b[7:0]});
            check("ovf2", {31'd0, ovf2}, {31'd0, e.o});
            check("busy_len2", run, 8);
          end
        end
        if (busy2) run++;
        else run = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) begin
      compared++; mismatched++;
      $display("FAIL idle_timeout3: busy still 1 expected 0");
    end
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (busy2 && n < 50) begin @(negedge clk); n++; end
    if (busy2) begin
      compared++; mismatched++;
      $display("FAIL idle_timeout2: busy still 1 expected 0");
    end
  endtask

  task automatic go(input logic [7:0] v, input logic [11:0] eb, input logic eo);
    wait_idle();
    q1.push_back(exp_t'{b: eb, o: eo});
    start = 1'b1; bin = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go2(input logic [7:0] v, input logic [7:0] eb, input logic eo);
    wait_idle2();
    q2.push_back(exp_t'{b: {4'd0, eb}, o: eo});
    start2 = 1'b1; bin2 = v;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_bcd",   {20'd0, bcd},  0);
    check("rst_ovf",   {31'd0, ovf},  0);
    check("rst_bcd2",  {24'd0, bcd2}, 0);
    check("rst_busy2", {31'd0, busy2}, 0);

    go(8'd0,   12'h000, 1'b0);
    go(8'd255, 12'h255, 1'b0);
    go(8'd9,   12'h009, 1'b0);
    go(8'd10,  12'h010, 1'b0);
    go(8'd15,  12'h015, 1'b0);

    // start during SHIFT must be ignored
    go(8'd200, 12'h200, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; bin = 8'd7;
    @(negedge clk);
    start = 1'b0;

    // start held high across two conversions; bin change mid-conversion has no effect
    wait_idle();
    q1.push_back(exp_t'{b: 12'h099, o: 1'b0});
    start = 1'b1; bin = 8'd99;
    @(negedge clk);
    bin = 8'd123;
    q1.push_back(exp_t'{b: 12'h123, o: 1'b0});
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL held_start_done: done=0 expected 1");
    end
    @(negedge clk);
    start = 1'b0;

    // reset mid-conversion discards the operation
    wait_idle();
    start = 1'b1; bin = 8'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_bcd",  {20'd0, bcd},  0);
    check("midrst_ovf",  {31'd0, ovf},  0);
    repeat (10) @(negedge clk);
    check("midrst_quiet_bcd", {20'd0, bcd}, 0);
    go(8'd77, 12'h077, 1'b0);

    for (int v = 0; v < 256; v++)
      go(8'(v), ref_bcd(v, 3), 1'b0);

    go2(8'd150, 8'h50, 1'b1);
    go2(8'd99,  8'h99, 1'b0);
    go2(8'd100, 8'h00, 1'b1);
    go2(8'd255, 8'h55, 1'b1);
    go2(8'd0,   8'h00, 1'b0);

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("pending_results", q1.size() + q2.size(), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
